// File: rtl/uart_printf_pkg.sv
// Shared constants for the queued printf-to-UART path: FSM encoding, EOL bytes, defaults.
// The optional CR/LF trailer is enabled with UART_PRINTF_QUEUE_CRLF_EN.
package uart_printf_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_EOL_CR = 2'd2;
    localparam logic [1:0] ST_EOL_LF = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned DEFAULT_MSG_BYTES = 22;
    localparam int unsigned DEFAULT_DEPTH     = 4;

endpackage

// File: rtl/uart_printf_queue_msg_fifo.sv
// Message FIFO: power-of-two depth, extra pointer MSB separates full from empty,
// and a push into a full FIFO is taken when a pop happens in the same cycle.
module msg_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign level_o = wrPtr_q - rdPtr_q;
    assign rdata_o = mem[rdPtr_q[AW-1:0]];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_printf_queue.sv
// Queues printf messages and streams them byte by byte into uart_tx (valid/ready).
// Define UART_PRINTF_QUEUE_CRLF_EN to append CR/LF after every message.
module uart_printf_queue
    import uart_printf_pkg::*;
#(
    parameter int unsigned MSG_BYTES = DEFAULT_MSG_BYTES,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    localparam int unsigned LEN_W = $clog2(MSG_BYTES + 1),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   printf,
    input  logic [MSG_BYTES*8-1:0] send_data,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic                   tx_data_ready,
    input  logic                   clear_overflow,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    output logic [7:0]             tx_cnt,
    output logic                   busy,
    output logic [LVL_W-1:0]       level,
    output logic                   overflow
);

    localparam int unsigned DATA_W  = MSG_BYTES * 8;
    localparam int unsigned ENTRY_W = LEN_W + DATA_W;

    logic [1:0]        state_q,   state_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [LEN_W-1:0]  len_q,     len_d;
    logic [7:0]        txCnt_q,   txCnt_d;
    logic              overflow_q;

    logic [LEN_W-1:0]   lenClamped;
    logic [ENTRY_W-1:0] fifoRdata;
    logic [LEN_W-1:0]   headLen;
    logic [DATA_W-1:0]  headData;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPop;
    logic [7:0]         lastIdx;

    assign lenClamped = (msg_len > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : msg_len;
    assign {headLen, headData} = fifoRdata;
    assign lastIdx = 8'(len_q) - 8'd1;

    msg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (printf),
        .pop_i   (fifoPop),
        .wdata_i ({lenClamped, send_data}),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (level)
    );

    // tx_cnt stays on the last index after the final byte so it never exceeds MSG_BYTES-1.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        len_d         = len_q;
        txCnt_d       = txCnt_q;
        fifoPop       = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shift_d = headData;
                    len_d   = headLen;
                    txCnt_d = 8'd0;
`ifdef UART_PRINTF_QUEUE_CRLF_EN
                    state_d = (headLen == '0) ? ST_EOL_CR : ST_SEND;
`else
                    state_d = (headLen == '0) ? ST_IDLE : ST_SEND;
`endif
                end
            end
            ST_SEND: begin
                tx_data       = shift_q[DATA_W-1 -: 8];
                tx_data_valid = 1'b1;
                if (tx_data_ready) begin
                    if (txCnt_q == lastIdx) begin
`ifdef UART_PRINTF_QUEUE_CRLF_EN
                        state_d = ST_EOL_CR;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        shift_d = shift_q << 8;
                        txCnt_d = txCnt_q + 8'd1;
                    end
                end
            end
`ifdef UART_PRINTF_QUEUE_CRLF_EN
            ST_EOL_CR: begin
                tx_data       = ASCII_CR;
                tx_data_valid = 1'b1;
                if (tx_data_ready) state_d = ST_EOL_LF;
            end
            ST_EOL_LF: begin
                tx_data       = ASCII_LF;
                tx_data_valid = 1'b1;
                if (tx_data_ready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            len_q   <= '0;
            txCnt_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            txCnt_q <= txCnt_d;
        end
    end

    // A dropped push wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (printf && fifoFull && !fifoPop) begin
            overflow_q <= 1'b1;
        end else if (clear_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign tx_cnt   = txCnt_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || !fifoEmpty;

endmodule
